// File: rtl/map_switch_ctrl.sv
// rtl/map_switch_ctrl.sv - sequences a mapper index change: wait for bus idle, blank, reset cores, settle, ack.
module map_switch_ctrl #(
  parameter int IDX_W       = 8,
  parameter int RST_CYC     = 16,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_req,
  input  logic [IDX_W-1:0] cfg_idx,
  output logic             cfg_busy,
  output logic             cfg_ack,
  output logic             cfg_err,
  input  logic             m2,
  input  logic             ss_act,
  output logic [IDX_W-1:0] map_idx_o,
  output logic             map_rst_o,
  output logic             out_blank_o
);

  localparam int TW     = $clog2(TIMEOUT_CYC);
  localparam int PH_MAX = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
  localparam int PW     = $clog2(PH_MAX + 1);

  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYC - 1);
  localparam logic [PW-1:0] RST_LAST  = PW'(RST_CYC - 1);
  localparam logic [PW-1:0] SET_LAST  = PW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_BLANK, S_RESET, S_SETTLE, S_DONE
  } state_e;

  state_e           state_q;
  logic             req_q;
  logic             m2_meta_q, m2_s_q, m2_prev_q;
  logic [TW-1:0]    timer_q;
  logic [PW-1:0]    cnt_q;
  logic [IDX_W-1:0] idx_l_q, map_idx_q;
  logic             busy_q, ack_q, err_q, map_rst_q, blank_q;

  logic req_edge;
  logic bus_idle;

  assign req_edge = cfg_req & ~req_q;
  // M2 must have been seen low on two consecutive synchronised samples.
  assign bus_idle = ~m2_s_q & ~m2_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      m2_meta_q <= 1'b0;
      m2_s_q    <= 1'b0;
      m2_prev_q <= 1'b0;
      timer_q   <= '0;
      cnt_q     <= '0;
      idx_l_q   <= '0;
      map_idx_q <= '0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      map_rst_q <= 1'b0;
      blank_q   <= 1'b0;
    end else begin
      m2_meta_q <= m2;
      m2_s_q    <= m2_meta_q;
      m2_prev_q <= m2_s_q;
      req_q     <= cfg_req;
      ack_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_edge) begin
            idx_l_q <= cfg_idx;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            timer_q <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus_idle && !ss_act) begin
            blank_q <= 1'b1;
            state_q <= S_BLANK;
          end else if ((timer_q == TIMER_MAX) && !ss_act) begin
            err_q   <= 1'b1;
            blank_q <= 1'b1;
            state_q <= S_BLANK;
          end else if (timer_q != TIMER_MAX) begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_BLANK: begin
          map_idx_q <= idx_l_q;
          map_rst_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= S_RESET;
        end
        S_RESET: begin
          if (cnt_q == RST_LAST) begin
            map_rst_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= S_SETTLE;
          end else begin
            cnt_q <= cnt_q + PW'(1);
          end
        end
        S_SETTLE: begin
          if (cnt_q == SET_LAST) begin
            blank_q <= 1'b0;
            ack_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + PW'(1);
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cfg_busy    = busy_q;
  assign cfg_ack     = ack_q;
  assign cfg_err     = err_q;
  assign map_idx_o   = map_idx_q;
  assign map_rst_o   = map_rst_q;
  assign out_blank_o = blank_q;

endmodule
